// File: rtl/shift_add_multiplier.sv
// Iterative unsigned WIDTHxWIDTH multiplier that sequences one partial-product
// accumulation per clock through a shared external adder.
module shift_add_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_co,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] phi;
  logic [WIDTH-1:0] plo;
  logic [WIDTH-1:0] m;
  logic [3:0]       cnt;

  // Each RUN edge shifts the 33-bit {carry, sum, plo} right by one, so the
  // carry out of the adder is never lost and the product stays exact.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      phi   <= '0;
      plo   <= '0;
      m     <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m     <= mcand;
            phi   <= '0;
            plo   <= mplier;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          phi <= {add_co, add_sum[WIDTH-1:1]};
          plo <= {add_sum[0], plo[WIDTH-1:1]};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Adder operands are parked at zero outside RUN so the shared adder sees
  // no activity from this block when it is not iterating.
  always_comb begin
    add_a = '0;
    add_b = '0;
    if (state == RUN) begin
      add_a = phi;
      add_b = plo[0] ? m : '0;
    end
  end

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign product = {phi, plo};

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier; supplies the external 16-bit adder
// and checks each scenario against hand-computed products and timing.
module tb_shift_add_multiplier;

  logic        Clk;
  logic        Reset;
  logic        start;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] add_sum;
  logic        add_co;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int checks;
  int errors;

  shift_add_multiplier #(.WIDTH(16)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .start  (start),
    .mcand  (mcand),
    .mplier (mplier),
    .add_a  (add_a),
    .add_b  (add_b),
    .add_sum(add_sum),
    .add_co (add_co),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  // Stand-in for the shared carry-select adder.
  assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Drives operands for one accepting edge, then scrambles them so the DUT
  // must rely on its latched copies. Returns at the negedge after acceptance.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    @(negedge Clk);
    start  = 1'b0;
    mcand  = 16'hDEAD;
    mplier = 16'hBEEF;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b expected 0", done); end
    checks++; if (product !== 32'h0) begin errors++; $display("[TB] FAIL reset_product got %h expected 00000000", product); end
    checks++; if (add_a !== 16'h0) begin errors++; $display("[TB] FAIL reset_add_a got %h expected 0000", add_a); end
    checks++; if (add_b !== 16'h0) begin errors++; $display("[TB] FAIL reset_add_b got %h expected 0000", add_b); end
    Reset = 1'b0;
    @(negedge Clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got %b expected 0", busy); end
  endtask

  task automatic test_small();
    logic [15:0] expB;
    applyStimulus(16'd3, 16'd5);
    for (int k = 1; k <= 16; k++) begin
      expB = (k == 1 || k == 3) ? 16'h0003 : 16'h0000;
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL small_busy it=%0d got busy=%b done=%b expected busy=1 done=0", k, busy, done); end
      checks++; if (add_b !== expB) begin errors++; $display("[TB] FAIL small_add_b it=%0d got %h expected %h", k, add_b, expB); end
      @(negedge Clk);
    end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL small_done got done=%b busy=%b expected done=1 busy=0", done, busy); end
    checks++; if (product !== 32'h0000000F) begin errors++; $display("[TB] FAIL small_product got %h expected 0000000F", product); end
    checks++; if (add_a !== 16'h0 || add_b !== 16'h0) begin errors++; $display("[TB] FAIL small_done_operands got a=%h b=%h expected 0000 0000", add_a, add_b); end
    @(negedge Clk);
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL small_done_pulse got %b expected 0", done); end
    checks++; if (product !== 32'h0000000F) begin errors++; $display("[TB] FAIL small_hold got %h expected 0000000F", product); end
  endtask

  task automatic test_max();
    applyStimulus(16'hFFFF, 16'hFFFF);
    for (int k = 1; k <= 16; k++) begin
      checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL max_latency it=%0d got busy=%b done=%b expected busy=1 done=0", k, busy, done); end
      @(negedge Clk);
    end
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL max_done got %b expected 1", done); end
    checks++; if (product !== 32'hFFFE0001) begin errors++; $display("[TB] FAIL max_product got %h expected FFFE0001", product); end
    @(negedge Clk);
  endtask

  task automatic test_zero();
    logic [15:0] as [2];
    logic [15:0] bs [2];
    as[0] = 16'h1234; bs[0] = 16'h0000;
    as[1] = 16'h0000; bs[1] = 16'hBEEF;
    for (int t = 0; t < 2; t++) begin
      applyStimulus(as[t], bs[t]);
      for (int k = 1; k <= 16; k++) begin
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL zero_latency case=%0d it=%0d got busy=%b done=%b expected busy=1 done=0", t, k, busy, done); end
        @(negedge Clk);
      end
      checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL zero_done case=%0d got %b expected 1", t, done); end
      checks++; if (product !== 32'h0) begin errors++; $display("[TB] FAIL zero_product case=%0d got %h expected 00000000", t, product); end
      @(negedge Clk);
    end
  endtask

  task automatic test_ignore_start();
    int doneCount;
    doneCount = 0;
    applyStimulus(16'h0100, 16'h0100);
    for (int k = 1; k <= 20; k++) begin
      if (k >= 5 && k <= 9) begin
        start  = 1'b1;
        mcand  = 16'hFFFF - 16'(k);
        mplier = 16'h0007 + 16'(k);
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        doneCount++;
        checks++; if (k != 17) begin errors++; $display("[TB] FAIL ignore_done_time got cycle %0d expected 17", k); end
        checks++; if (product !== 32'h00010000) begin errors++; $display("[TB] FAIL ignore_product got %h expected 00010000", product); end
      end
      @(negedge Clk);
    end
    checks++; if (doneCount != 1) begin errors++; $display("[TB] FAIL ignore_done_count got %0d expected 1", doneCount); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ignore_restart got busy=%b expected 0", busy); end
  endtask

  task automatic test_reset_mid();
    applyStimulus(16'h00FF, 16'h00FF);
    repeat (6) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_flags got busy=%b done=%b expected 0 0", busy, done); end
    checks++; if (product !== 32'h0) begin errors++; $display("[TB] FAIL midreset_product got %h expected 00000000", product); end
    checks++; if (add_a !== 16'h0 || add_b !== 16'h0) begin errors++; $display("[TB] FAIL midreset_operands got a=%h b=%h expected 0000 0000", add_a, add_b); end
    repeat (20) begin
      @(negedge Clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_stray got busy=%b done=%b expected 0 0", busy, done); end
    end
    applyStimulus(16'h00FF, 16'h00FF);
    repeat (16) @(negedge Clk);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL midreset_redo_done got %b expected 1", done); end
    checks++; if (product !== 32'h0000FE01) begin errors++; $display("[TB] FAIL midreset_redo_product got %h expected 0000FE01", product); end
    @(negedge Clk);
  endtask

  task automatic test_back_to_back();
    int doneCount;
    int expTime [3];
    expTime[0] = 17; expTime[1] = 35; expTime[2] = 53;
    doneCount = 0;
    start  = 1'b1;
    mcand  = 16'd7;
    mplier = 16'd9;
    for (int n = 1; n <= 60; n++) begin
      @(negedge Clk);
      if (done === 1'b1) begin
        if (doneCount < 3) begin
          checks++; if (n != expTime[doneCount]) begin errors++; $display("[TB] FAIL b2b_spacing pulse=%0d got cycle %0d expected %0d", doneCount, n, expTime[doneCount]); end
        end
        checks++; if (product !== 32'h0000003F) begin errors++; $display("[TB] FAIL b2b_product pulse=%0d got %h expected 0000003F", doneCount, product); end
        doneCount++;
      end
    end
    checks++; if (doneCount != 3) begin errors++; $display("[TB] FAIL b2b_done_count got %0d expected 3", doneCount); end
    start = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Reset  = 1'b1;
    start  = 1'b0;
    mcand  = 16'h0;
    mplier = 16'h0;
    @(negedge Clk);
    test_reset();
    test_small();
    test_max();
    test_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
